i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave_if.sv | 24 ++
 rtl/i2c_slave.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_slave.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_if.sv
// Bench-side grouping of the I2C pins and write-strobe outputs.
// sda is the wired-AND of the master and target open-drain drivers.
interface i2c_slave_if;
  logic       scl;
  logic       sda_m;
  logic       sda_s;
  logic       sda;
  logic       wr_strobe;
  logic [1:0] wr_index;
  logic [7:0] wr_data;
  logic       busy;

  assign sda = sda_m & sda_s;

  modport master (
    output scl, sda_m,
    input  sda, sda_s, wr_strobe, wr_index, wr_data, busy
  );

  modport slave (
    input  scl, sda,
    output sda_s, wr_strobe, wr_index, wr_data, busy
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C target with a 4x8 register file and auto-incrementing pointer.
// Define I2C_SLAVE_GCALL_EN to also accept general-call writes to 7'h00.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       i2c_scl_in,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_out,
  output logic       wr_strobe,
  output logic [1:0] wr_index,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, PTR,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        scl_s_q, sda_s_q;
  logic              scl_d_q, sda_d_q;
  logic [1:0]        arm_q, arm_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        sh_q, sh_d;
  logic [1:0]        ptr_q, ptr_d;
  logic              sda_q, sda_d;
  logic              busy_q, busy_d;
  logic              stb_q, stb_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        wd_q, wd_d;
  logic [3:0][7:0]   regs_q, regs_d;

  logic scl, sda, armed;
  logic scl_rise, scl_fall;
  logic start, stop;
  logic gcall, match;

  assign scl   = scl_s_q[1];
  assign sda   = sda_s_q[1];
  assign armed = (arm_q == 2'd3);

  assign scl_rise = armed & scl & ~scl_d_q;
  assign scl_fall = armed & ~scl & scl_d_q;
  assign start = armed & scl & scl_d_q & ~sda & sda_d_q;
  assign stop  = armed & scl & scl_d_q & sda & ~sda_d_q;

`ifdef I2C_SLAVE_GCALL_EN
  assign gcall = (sh_q == 8'h00);
`else
  assign gcall = 1'b0;
`endif

  assign match = (sh_q[7:1] == SLAVE_ADDR) | gcall;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      scl_s_q <= 2'b11;
      sda_s_q <= 2'b11;
      scl_d_q <= 1'b1;
      sda_d_q <= 1'b1;
      arm_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ptr_q   <= '0;
      sda_q   <= 1'b1;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      idx_q   <= '0;
      wd_q    <= '0;
      regs_q  <= '0;
    end else begin
      scl_s_q <= {scl_s_q[0], i2c_scl_in};
      sda_s_q <= {sda_s_q[0], i2c_sda_in};
      scl_d_q <= scl;
      sda_d_q <= sda;
      arm_q   <= arm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      sda_q   <= sda_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    sda_d   = sda_q;
    busy_d  = busy_q;
    stb_d   = 1'b0;
    idx_d   = idx_q;
    wd_d    = wd_q;
    regs_d  = regs_q;

    // Hold off bus events until the sync chain reflects the pins.
    if (arm_q != 2'd3) begin
      arm_d = arm_q + 2'd1;
    end

    if (stop) begin
      state_d = IDLE;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else if (start) begin
      state_d = ADDR;
      sda_d   = 1'b1;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        ADDR: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (match) begin
              state_d = ADDR_ACK;
              sda_d   = 1'b0;
              busy_d  = 1'b1;
            end else begin
              state_d = IDLE;
              sda_d   = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (sh_q[0]) begin
              state_d = RD_DATA;
              sh_d    = regs_q[ptr_q];
              sda_d   = regs_q[ptr_q][7];
            end else begin
              state_d = PTR;
              sda_d   = 1'b1;
            end
          end
        end
        PTR, WR_DATA: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            state_d = WR_ACK;
            sda_d   = 1'b0;
            if (state_q == PTR) begin
              ptr_d = sh_q[1:0];
            end else begin
              regs_d[ptr_q] = sh_q;
              stb_d = 1'b1;
              idx_d = ptr_q;
              wd_d  = sh_q;
              ptr_d = ptr_q + 2'd1;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_d = WR_DATA;
            sda_d   = 1'b1;
            cnt_d   = '0;
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = RD_ACK;
              sda_d   = 1'b1;
              ptr_d   = ptr_q + 2'd1;
              cnt_d   = '0;
            end else begin
              sda_d = sh_q[6];
              sh_d  = {sh_q[6:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && sda) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else if (scl_fall) begin
            state_d = RD_DATA;
            sh_d    = regs_q[ptr_q];
            sda_d   = regs_q[ptr_q][7];
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  assign i2c_sda_out = sda_q;
  assign wr_strobe   = stb_q;
  assign wr_index    = idx_q;
  assign wr_data     = wd_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave: directed table,
// corner-case sequences and a randomized run against a register model.
module tb_i2c_slave;

  localparam int H = 9;
`ifdef I2C_SLAVE_GCALL_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  i2c_slave_if bus ();

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk_in      (clk),
    .reset_in    (rst_n),
    .i2c_scl_in  (bus.scl),
    .i2c_sda_in  (bus.sda),
    .i2c_sda_out (bus.sda_s),
    .wr_strobe   (bus.wr_strobe),
    .wr_index    (bus.wr_index),
    .wr_data     (bus.wr_data),
    .busy        (bus.busy)
  );

  logic [9:0] sq[$];

  always @(negedge clk) begin
    if (bus.wr_strobe === 1'b1) begin
      sq.push_back({bus.wr_index, bus.wr_data});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic s);
    bus.sda_m = b;
    wc(H);
    bus.scl = 1'b1;
    wc(H / 2);
    s = bus.sda;
    wc(H - H / 2);
    bus.scl = 1'b0;
    wc(1);
  endtask

  task automatic start_c();
    bus.sda_m = 1'b1;
    wc(H);
    bus.scl = 1'b1;
    wc(H);
    bus.sda_m = 1'b0;
    wc(H);
    bus.scl = 1'b0;
    wc(1);
  endtask

  task automatic stop_c();
    bus.sda_m = 1'b0;
    wc(H);
    bus.scl = 1'b1;
    wc(H);
    bus.sda_m = 1'b1;
    wc(H);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(b[i], s);
    bit_x(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, s);
      b[i] = s;
    end
    bit_x(nack, s);
  endtask

  task automatic xfer(input  logic [7:0]  a,
                      input  int          n,
                      input  logic [31:0] d,
                      output logic        aack,
                      output logic [3:0]  dack,
                      output logic [31:0] rd,
                      output logic        bmid,
                      output logic        bend);
    logic       k_ack;
    logic [7:0] k_b;
    sq.delete();
    dack = '0;
    rd   = '0;
    start_c();
    send_byte(a, aack);
    bmid = bus.busy;
    if (aack) begin
      for (int k = 0; k < n; k++) begin
        if (!a[0]) begin
          send_byte(d[31-8*k -: 8], k_ack);
          dack[k] = k_ack;
        end else begin
          recv_byte(k == n - 1, k_b);
          rd[31-8*k -: 8] = k_b;
        end
      end
    end
    stop_c();
    bend = bus.busy;
  endtask

  typedef struct {
    logic [7:0]  a;
    int          n;
    logic [31:0] d;
    logic        eaack;
    int          enstb;
    logic [9:0]  efirst;
    logic [9:0]  elast;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[9];

  logic [7:0]  m_reg[4];
  logic [1:0]  m_ptr;
  logic [9:0]  eq[$];

  initial begin
    logic        aack, bmid, bend, s;
    logic [3:0]  dack, emask;
    logic [31:0] rd, erd, d;
    logic [7:0]  a, b;
    int          n, r;
    logic        match;

    tbl[0] = '{8'hA0, 2, 32'h015A0000, 1'b1, 1,
               10'h15A, 10'h15A, 32'h0};
    tbl[1] = '{8'hA0, 3, 32'h03112200, 1'b1, 2,
               10'h311, 10'h022, 32'h0};
    tbl[2] = '{8'hA0, 1, 32'h03000000, 1'b1, 0,
               10'h0, 10'h0, 32'h0};
    tbl[3] = '{8'hA1, 2, 32'h0, 1'b1, 0,
               10'h0, 10'h0, 32'h11220000};
    tbl[4] = '{8'hB0, 1, 32'h55000000, 1'b0, 0,
               10'h0, 10'h0, 32'h0};
    tbl[5] = '{8'hA1, 1, 32'h0, 1'b1, 0,
               10'h0, 10'h0, 32'h5A000000};
    if (GC) begin
      tbl[6] = '{8'h00, 2, 32'h02770000, 1'b1, 1,
                 10'h277, 10'h277, 32'h0};
      tbl[8] = '{8'hA1, 1, 32'h0, 1'b1, 0,
                 10'h0, 10'h0, 32'h11000000};
    end else begin
      tbl[6] = '{8'h00, 2, 32'h02770000, 1'b0, 0,
                 10'h0, 10'h0, 32'h0};
      tbl[8] = '{8'hA1, 1, 32'h0, 1'b1, 0,
                 10'h0, 10'h0, 32'h0};
    end
    tbl[7] = '{8'h01, 1, 32'h0, 1'b0, 0,
               10'h0, 10'h0, 32'h0};

    bus.scl   = 1'b1;
    bus.sda_m = 1'b1;
    rst_n     = 1'b0;
    wc(5);
    chk("rst sda_out", 32'(bus.sda_s), 32'h1);
    chk("rst wr_strobe", 32'(bus.wr_strobe), 32'h0);
    chk("rst wr_index", 32'(bus.wr_index), 32'h0);
    chk("rst wr_data", 32'(bus.wr_data), 32'h0);
    chk("rst busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    wc(5);

    for (int i = 0; i < 9; i++) begin
      xfer(tbl[i].a, tbl[i].n, tbl[i].d,
           aack, dack, rd, bmid, bend);
      emask = (!tbl[i].a[0] && tbl[i].eaack) ?
              4'((1 << tbl[i].n) - 1) : 4'h0;
      chk($sformatf("v%0d addr ack", i),
          32'(aack), 32'(tbl[i].eaack));
      chk($sformatf("v%0d busy mid", i),
          32'(bmid), 32'(tbl[i].eaack));
      chk($sformatf("v%0d data acks", i),
          32'(dack), 32'(emask));
      chk($sformatf("v%0d strobes", i),
          sq.size(), tbl[i].enstb);
      if (tbl[i].enstb > 0 && sq.size() == tbl[i].enstb) begin
        chk($sformatf("v%0d first stb", i),
            32'(sq[0]), 32'(tbl[i].efirst));
        chk($sformatf("v%0d last stb", i),
            32'(sq[sq.size()-1]), 32'(tbl[i].elast));
      end
      chk($sformatf("v%0d read data", i), rd, tbl[i].erd);
      chk($sformatf("v%0d busy end", i), 32'(bend), 32'h0);
    end

    // Repeated START four bits into a data byte must not write.
    sq.delete();
    start_c();
    send_byte(8'hA0, aack);
    send_byte(8'h00, aack);
    for (int i = 0; i < 4; i++) bit_x(1'b1, s);
    start_c();
    send_byte(8'hA1, aack);
    chk("rs addr ack", 32'(aack), 32'h1);
    recv_byte(1'b1, b);
    stop_c();
    chk("rs no strobe", sq.size(), 0);
    chk("rs reg0 kept", 32'(b), 32'h22);

    // Reset while the target is driving a 0 data bit.
    start_c();
    send_byte(8'hA0, aack);
    send_byte(8'h00, aack);
    start_c();
    send_byte(8'hA1, aack);
    for (int i = 0; i < 4; i++) bit_x(1'b1, s);
    wc(4);
    chk("rd bit3 driven", 32'(bus.sda_s), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst sda release", 32'(bus.sda_s), 32'h1);
    chk("rst busy drop", 32'(bus.busy), 32'h0);
    wc(3);
    rst_n = 1'b1;
    wc(2);
    stop_c();
    xfer(8'hA1, 4, 32'h0, aack, dack, rd, bmid, bend);
    chk("post-rst ack", 32'(aack), 32'h1);
    chk("post-rst regs", rd, 32'h0);
    chk("post-rst strobes", sq.size(), 0);

    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_ptr = 2'd0;

    for (int t = 0; t < 20; t++) begin
      r = $urandom_range(0, 9);
      if (r < 4) a = 8'hA0;
      else if (r < 8) a = 8'hA1;
      else a = 8'($urandom_range(0, 255));
      n = a[0] ? $urandom_range(1, 4) : $urandom_range(0, 4);
      d = $urandom;

      match = (a[7:1] == 7'h50) || (GC && a == 8'h00);
      eq.delete();
      erd = '0;
      if (match && !a[0]) begin
        for (int k = 0; k < n; k++) begin
          b = d[31-8*k -: 8];
          if (k == 0) begin
            m_ptr = b[1:0];
          end else begin
            eq.push_back({m_ptr, b});
            m_reg[m_ptr] = b;
            m_ptr = m_ptr + 2'd1;
          end
        end
      end else if (match) begin
        for (int k = 0; k < n; k++) begin
          erd[31-8*k -: 8] = m_reg[m_ptr];
          m_ptr = m_ptr + 2'd1;
        end
      end
      emask = (match && !a[0]) ? 4'((1 << n) - 1) : 4'h0;

      xfer(a, n, d, aack, dack, rd, bmid, bend);
      chk($sformatf("r%0d a=%h ack", t, a),
          32'(aack), 32'(match));
      chk($sformatf("r%0d data acks", t),
          32'(dack), 32'(emask));
      chk($sformatf("r%0d read", t), rd, erd);
      chk($sformatf("r%0d strobes", t), sq.size(), eq.size());
      for (int k = 0; k < eq.size() && k < sq.size(); k++) begin
        chk($sformatf("r%0d stb%0d", t, k),
            32'(sq[k]), 32'(eq[k]));
      end
      chk($sformatf("r%0d busy end", t), 32'(bend), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
